// File: rtl/cube_button_ctrl.sv
// cube_button_ctrl: user-input controller for the 4x4x4 LED cube.
// Generates the debouncer sample tick, latches next/prev/run-pause release pulses,
// arbitrates them round-robin and applies one event at a time, with a hold-off
// window of sample ticks between events.
// Optional feature: define CUBE_AUTO_CYCLE_EN to advance the mode automatically
// every AUTO_TICKS sample ticks while running and idle.
module cube_button_ctrl #(
    parameter int unsigned CLK_DIV       = 50000,
    parameter int unsigned NUM_MODES     = 8,
    parameter int unsigned HOLDOFF_TICKS = 4,
    parameter int unsigned AUTO_TICKS    = 200,
    localparam int unsigned MW           = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    btn_pulse,
    output logic          sample_tick,
    output logic [MW-1:0] mode,
    output logic          running,
    output logic          mode_changed,
    output logic          busy
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned HOLD_W = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;

    localparam logic [DIV_W-1:0]  DivLast  = DIV_W'(CLK_DIV - 1);
    localparam logic [MW-1:0]     ModeLast = MW'(NUM_MODES - 1);
    localparam logic [HOLD_W-1:0] HoldLast =
        HOLD_W'((HOLDOFF_TICKS > 0) ? HOLDOFF_TICKS - 1 : 0);

    // Grant codes double as button indices.
    localparam logic [1:0] GntNext = 2'd0;
    localparam logic [1:0] GntPrev = 2'd1;
    localparam logic [1:0] GntRun  = 2'd2;

    // Reject nonsensical parameter sets at elaboration.
    if (CLK_DIV < 2 || NUM_MODES < 2 || AUTO_TICKS < 1) begin : g_param_check
        $error("cube_button_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StHoldoff
    } state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [2:0]        pending_q;
    logic [1:0]        rr_ptr_q;
    logic [1:0]        gnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [MW-1:0]     mode_q;
    logic              running_q;
    logic              mode_changed_q;

    logic              gnt_valid;
    logic [1:0]        gnt_idx;
    logic [2:0]        pend_clr;

    assign sample_tick  = (div_cnt_q == DivLast);
    assign mode         = mode_q;
    assign running      = running_q;
    assign mode_changed = mode_changed_q;
    assign busy         = (state_q != StIdle);

`ifdef CUBE_AUTO_CYCLE_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_TICKS + 1);
    localparam logic [AUTO_W-1:0] AutoLast = AUTO_W'(AUTO_TICKS);

    logic [AUTO_W-1:0] auto_cnt_q;
    logic              auto_fire;

    // Auto advance only when no button event is waiting (buttons win).
    assign auto_fire = running_q && (pending_q == 3'b000) && (auto_cnt_q == AutoLast);

    // Auto-advance timer: counts idle ticks while running, restarts on applied next/prev.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_q <= '0;
        end else if (state_q == StApply && gnt_q != GntRun) begin
            auto_cnt_q <= '0;
        end else if (state_q == StIdle && running_q && sample_tick && auto_cnt_q != AutoLast) begin
            auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
        end
    end
`else
    // No auto timer: mode moves only on button events, running is a plain flag.
`endif

    // Free-running sample tick divider, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst || sample_tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Round-robin pick: first pending requester at or after rr_ptr, wrapping 2->0.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        for (int unsigned k = 0; k < 3; k++) begin
            logic [1:0] cand;
            cand = 2'((32'(rr_ptr_q) + k) % 3);
            if (!gnt_valid && pending_q[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Pending bit of the granted button is dropped as the grant is taken.
    always_comb begin
        pend_clr = 3'b000;
        if (state_q == StIdle && gnt_valid) begin
            pend_clr[gnt_idx] = 1'b1;
        end
    end

    // Event FSM: latch pulses, grant, apply one event, then sit out the hold-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pending_q      <= 3'b000;
            rr_ptr_q       <= 2'd0;
            gnt_q          <= 2'd0;
            hold_cnt_q     <= '0;
            mode_q         <= '0;
            running_q      <= 1'b1;
            mode_changed_q <= 1'b0;
        end else begin
            // A new pulse on the same edge as its clear is kept.
            pending_q      <= (pending_q & ~pend_clr) | btn_pulse;
            mode_changed_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        gnt_q    <= gnt_idx;
                        rr_ptr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
                        state_q  <= StApply;
                    end
`ifdef CUBE_AUTO_CYCLE_EN
                    else if (auto_fire) begin
                        gnt_q   <= GntNext;
                        state_q <= StApply;
                    end
`endif
                end

                StApply: begin
                    unique case (gnt_q)
                        GntNext: begin
                            mode_q         <= (mode_q == ModeLast) ? '0 : mode_q + MW'(1);
                            mode_changed_q <= 1'b1;
                        end
                        GntPrev: begin
                            mode_q         <= (mode_q == '0) ? ModeLast : mode_q - MW'(1);
                            mode_changed_q <= 1'b1;
                        end
                        default: begin
                            running_q <= ~running_q;
                        end
                    endcase
                    hold_cnt_q <= '0;
                    state_q    <= (HOLDOFF_TICKS == 0) ? StIdle : StHoldoff;
                end

                StHoldoff: begin
                    if (sample_tick) begin
                        if (hold_cnt_q == HoldLast) begin
                            hold_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/cube_button_ctrl.md
Name: cube_button_ctrl

Overview:
- Central user-input controller for the 4x4x4 LED cube.
- Generates the slow sample tick that paces the button debouncers.
- Collects their single-cycle release pulses (next / prev / run-pause) and arbitrates simultaneous events round-robin.
- Applies each event to the cube's pattern-mode register and run flag, then enforces a hold-off window before accepting the next event.

Parameters:
- CLK_DIV, 50000: clk cycles per sample_tick period; legal range ≥2.
- NUM_MODES, 8: number of cube animation patterns; legal range ≥2.
- HOLDOFF_TICKS, 4: sample ticks of event hold-off after each applied event; 0 means no hold-off.
- AUTO_TICKS, 200: sample ticks between automatic mode advances; used only with CUBE_AUTO_CYCLE_EN.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  synchronous reset, active-high.
- btn_pulse  in  3  debounced one-cycle pulses, synchronous to clk; [0]=next, [1]=prev, [2]=run/pause.
- sample_tick  out  1  one-clk-wide debouncer sample strobe, once per CLK_DIV cycles.
- mode  out  MW  current pattern index; MW = max(1, clog2(NUM_MODES)).
- running  out  1  animation run flag.
- mode_changed  out  1  one-cycle strobe, high in the cycle mode takes a new value.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Interface (decided):
  - One clock, clk.
  - Reset rst is synchronous and active-high; all state is sampled at the clk rising edge.
- Reset values:
  - mode=0, running=1, mode_changed=0, sample_tick=0, busy=0.
  - pending=000, rr_ptr=0, state=IDLE, all counters 0.
- Reset mid-operation:
  - Discards pending events, any hold-off and any in-flight APPLY.
  - No mode_changed is emitted.
- Tick divider:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - sample_tick is high in the cycle the count equals CLK_DIV-1.
  - First tick occurs in cycle CLK_DIV after rst deasserts.
  - The divider free-runs, independent of the FSM.
- Pending latches:
  - pending[i] is set at the clk edge where btn_pulse[i]=1.
  - It is cleared when button i is granted.
  - Set and clear in the same edge: set wins, so the new pulse is kept.
  - Multiple pulses before a grant collapse into one event.
  - Latching continues in every state, including HOLDOFF.
- Arbiter:
  - Round-robin over 3 requesters.
  - The search starts at rr_ptr and wraps 2→0.
  - On a grant g, rr_ptr ← (g+1) mod 3.
- FSM states and transitions:
  - IDLE: busy=0. If pending≠0, register grant g, clear pending[g], go to APPLY.
  - APPLY, one cycle: at the end of the cycle, update per g:
    - next: mode ← (mode==NUM_MODES-1) ? 0 : mode+1.
    - prev: mode ← (mode==0) ? NUM_MODES-1 : mode-1.
    - run/pause: running ← ~running; mode is unchanged.
    - mode_changed=1 in the following cycle, for next/prev only.
    - Then go to HOLDOFF, or to IDLE if HOLDOFF_TICKS=0.
  - HOLDOFF: count sample_tick pulses; after the HOLDOFF_TICKS-th tick, go to IDLE.
- Latency, with the FSM idle and no pending events:
  - btn_pulse high in cycle N → pending set in N+1.
  - APPLY in N+2.
  - mode updated and mode_changed=1 in N+3.
- Wrap-around:
  - prev at mode=0 gives NUM_MODES-1.
  - next at NUM_MODES-1 gives 0.
- Non-power-of-2 NUM_MODES: mode never exceeds NUM_MODES-1.

Optional Feature:
- Macro: CUBE_AUTO_CYCLE_EN.
- Defined:
  - An auto counter counts sample ticks while running=1 and state=IDLE.
  - When it reaches AUTO_TICKS with pending=0, it performs a "next" through APPLY: same wrap, same mode_changed, then HOLDOFF.
  - The counter clears on any applied next/prev event and on rst.
  - It holds its value while running=0.
  - Button events take priority over an auto advance in the same cycle.
- Undefined:
  - No auto counter exists.
  - mode changes only via buttons.
  - running is a plain output flag.

Test Plan (CLK_DIV=4, HOLDOFF_TICKS=2, NUM_MODES=5):
1. Release rst, count ticks → sample_tick high in cycles 4, 8, 12; all outputs at reset values before cycle 4.
2. Pulse btn[0] in cycle 20 (idle) → mode 0→1 and mode_changed=1 exactly in cycle 23; busy until 2 sample ticks later.
3. From mode=0, pulse btn[1] → mode=4. From mode=4, pulse btn[0] → mode=0.
4. Pulse btn[0], btn[1], btn[2] in the same cycle with rr_ptr=0 → applied in order next, prev, run. Result: mode returns to its original value, running=0, two mode_changed strobes separated by the hold-off.
5. Pulse btn[0] three times during HOLDOFF → exactly one extra increment after the hold-off ends.
6. Assert rst during APPLY → mode=0 and running=1 next cycle, no mode_changed strobe. With CUBE_AUTO_CYCLE_EN and AUTO_TICKS=3, idle running → mode advances every 3 sample ticks plus the hold-off.
